// File: rtl/slice_arb_pkg.sv
// slice_arb_pkg: shared definitions for the slice bus arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, GRANT_A, GRANT_B)
//   MSB_IDX / LSB_IDX  : index range of the model.i0 word, [2:-2]
//   WORD_W             : width of that word
//   SRC_A / SRC_B      : m_src encodings for the two requesters
//   word_t             : descending-indexed word type [2:-2]
package slice_arb_pkg;

  localparam int MSB_IDX = 2;
  localparam int LSB_IDX = -2;
  localparam int WORD_W  = MSB_IDX - LSB_IDX + 1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  typedef logic [MSB_IDX:LSB_IDX] word_t;

endpackage

// File: rtl/slice_out_stage.sv
// slice_out_stage: single registered valid/ready output slice.
//   clk, rst_n        : clock, async active-low reset
//   load              : an upstream beat is accepted this cycle
//   ld_data, ld_src   : word and source tag of that beat
//   space             : register can take a beat this cycle (!m_valid || m_ready)
//   m_valid/m_data/m_src/m_ready : downstream valid/ready interface
//
// Handshake: a beat moves when valid && ready are both high at the rising
// edge. While valid is high and ready is low, valid and data are held
// stable. Here the register is refilled in the same cycle it drains, so a
// back-to-back stream needs no bubble.
module slice_out_stage
  import slice_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t ld_data,
  input  logic  ld_src,
  output logic  space,
  output logic  m_valid,
  output word_t m_data,
  output logic  m_src,
  input  logic  m_ready
);

  assign space = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= SRC_A;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= ld_data;
      m_src   <= ld_src;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/slice_bus_arbiter.sv
// slice_bus_arbiter: round-robin packet arbiter sharing one model.i0 port
// between requester A (word [2:-2]) and requester B (word [-2:2]).
//   BURST_MAX          : max beats per grant before forced rotation (>= 1)
//   clk, rst_n         : clock, async active-low reset
//   a_valid/a_data/a_last/a_ready : requester A
//   b_valid/b_data/b_last/b_ready : requester B
//   m_valid/m_data/m_src/m_ready  : registered output toward model.i0
//   grant              : one-hot {B,A} current grant, 0 when idle
//   dbg_state          : arbiter FSM state, for observation only
module slice_bus_arbiter
  import slice_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [MSB_IDX:LSB_IDX] a_data,
  input  logic                   a_last,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [LSB_IDX:MSB_IDX] b_data,
  input  logic                   b_last,
  output logic                   b_ready,
  output logic                   m_valid,
  output word_t                  m_data,
  output logic                   m_src,
  input  logic                   m_ready,
  output logic [1:0]             grant,
  output arb_state_e             dbg_state
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_e       state;
  logic             ptr;
  logic [CNT_W-1:0] cnt;

  logic  space;
  logic  a_hs;
  logic  b_hs;
  logic  load;
  word_t b_mapped;
  word_t ld_data;
  logic  ld_src;

  // B is remapped by index, not by position: b_data[-2] (its leftmost bit)
  // lands on m_data[-2] (the rightmost bit of the output word).
  always_comb begin
    b_mapped = '0;
    for (int k = LSB_IDX; k <= MSB_IDX; k++) begin
      b_mapped[k] = b_data[k];
    end
  end

  // Ready follows the output register's free space combinationally so a
  // granted stream runs at one beat per cycle while m_ready stays high.
  assign a_ready = (state == GRANT_A) && space;
  assign b_ready = (state == GRANT_B) && space;
  assign a_hs    = a_valid && a_ready;
  assign b_hs    = b_valid && b_ready;
  assign load    = a_hs || b_hs;
  assign ld_data = b_hs ? b_mapped : word_t'(a_data);
  assign ld_src  = b_hs ? SRC_B : SRC_A;

  assign dbg_state = state;

  // Grants are whole packets; a valid drop mid-packet keeps the grant.
  // Every grant ends in IDLE, which costs one bubble per grant change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 2'b00;
      ptr   <= SRC_A;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid && (!b_valid || ptr == SRC_A)) begin
            state <= GRANT_A;
            grant <= 2'b01;
          end else if (b_valid) begin
            state <= GRANT_B;
            grant <= 2'b10;
          end
        end
        GRANT_A: begin
          if (a_hs) begin
            if (a_last || cnt == CNT_LAST) begin
              state <= IDLE;
              grant <= 2'b00;
              ptr   <= SRC_B;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GRANT_B: begin
          if (b_hs) begin
            if (b_last || cnt == CNT_LAST) begin
              state <= IDLE;
              grant <= 2'b00;
              ptr   <= SRC_A;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  slice_out_stage u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (ld_data),
    .ld_src  (ld_src),
    .space   (space),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_src   (m_src),
    .m_ready (m_ready)
  );

endmodule

// File: tb/tb_slice_bus_arbiter.sv
// tb_slice_bus_arbiter: self-checking bench for slice_bus_arbiter.
module tb_slice_bus_arbiter;
  import slice_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_last, a_ready;
  logic [2:-2] a_data;
  logic        b_valid, b_last, b_ready;
  logic [-2:2] b_data;
  logic        m_valid, m_src, m_ready;
  logic [2:-2] m_data;
  logic [1:0]  grant;
  arb_state_e  dbg_state;

  slice_bus_arbiter #(.BURST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_src     (m_src),
    .m_ready   (m_ready),
    .grant     (grant),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output word seen for a B vector: position order reverses because the
  // mapping is by index ([-2:2] leftmost bit is index -2, the output LSB).
  function automatic logic [4:0] bitrev(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int         out_cyc[$];
  bit         sb_en = 1'b0;
  logic [5:0] mon_e;

  always @(negedge clk) begin
    if (sb_en && rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_beat", {m_src, m_data}, mon_e);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  typedef struct packed {
    logic [4:0] d;
    logic       last;
  } beat_t;

  beat_t a_q[$];
  beat_t b_q[$];

  task automatic run_a();
    beat_t bt;
    int w;
    while (a_q.size() > 0) begin
      bt = a_q.pop_front();
      a_valid = 1'b1; a_data = bt.d; a_last = bt.last;
      w = 0;
      do begin @(negedge clk); w++; end while (!a_ready && w < 200);
      if (!a_ready) begin
        check("a_timeout", w, 0);
        a_valid = 1'b0;
        a_q.delete();
        return;
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
    end
  endtask

  task automatic run_b();
    beat_t bt;
    int w;
    while (b_q.size() > 0) begin
      bt = b_q.pop_front();
      b_valid = 1'b1; b_data = bt.d; b_last = bt.last;
      w = 0;
      do begin @(negedge clk); w++; end while (!b_ready && w < 200);
      if (!b_ready) begin
        check("b_timeout", w, 0);
        b_valid = 1'b0;
        b_q.delete();
        return;
      end
      @(posedge clk); #1;
      b_valid = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_src"}, m_src, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [4:0] r;
  logic [5:0] held;
  bit         bp_on;
  int         w0;

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    a_valid = 0; a_data = '0; a_last = 0;
    b_valid = 0; b_data = '0; b_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;

    // single A beat: ready one cycle after request, data one cycle later
    exp_q.push_back({SRC_A, 5'b10110});
    a_valid = 1'b1; a_data = 5'b10110; a_last = 1'b1;
    @(negedge clk);
    check("t1_ready_c0", a_ready, 0);
    @(negedge clk);
    check("t1_ready_c1", a_ready, 1);
    check("t1_grant", grant, 2'b01);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("t1_m_valid", m_valid, 1);
    check("t1_m_src", m_src, 0);
    check("t1_m_data", m_data, 5'b10110);
    wait_drain("t1_drain");

    // B index mapping, fixed vector then random beats
    b_q.push_back('{d: 5'b10000, last: 1'b0});
    exp_q.push_back({SRC_B, 5'b00001});
    for (int i = 0; i < 3; i++) begin
      r = 5'($urandom_range(0, 31));
      b_q.push_back('{d: r, last: (i == 2)});
      exp_q.push_back({SRC_B, bitrev(r)});
    end
    run_b();
    wait_drain("t2_drain");

    // asynchronous reset in the middle of an A burst
    sb_en = 1'b0;
    a_valid = 1'b1; a_last = 1'b0; a_data = 5'b01101;
    repeat (3) @(posedge clk);
    #1;
    check("t3_pre_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t3_async");
    a_valid = 1'b0; a_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;

    // both requesting, last on every beat: A first after reset, then alternate
    out_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      r = 5'($urandom_range(0, 31));
      a_q.push_back('{d: r, last: 1'b1});
      exp_q.push_back({SRC_A, r});
      r = 5'($urandom_range(0, 31));
      b_q.push_back('{d: r, last: 1'b1});
      exp_q.push_back({SRC_B, bitrev(r)});
    end
    fork
      run_a();
      run_b();
      begin
        @(negedge clk);
        @(negedge clk);
        check("t4_first_grant", grant, 2'b01);
      end
    join
    wait_drain("t4_drain");
    check("t4_n_out", out_cyc.size(), 6);
    for (int i = 1; i < out_cyc.size(); i++)
      check("t4_gap", out_cyc[i] - out_cyc[i-1], 2);

    // 6-beat A packet with B waiting: split after BURST_MAX beats
    out_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      r = 5'($urandom_range(0, 31));
      a_q.push_back('{d: r, last: (i == 5)});
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({SRC_A, a_q[i].d});
    for (int i = 0; i < 2; i++) begin
      r = 5'($urandom_range(0, 31));
      b_q.push_back('{d: r, last: (i == 1)});
      exp_q.push_back({SRC_B, bitrev(r)});
    end
    for (int i = 4; i < 6; i++) exp_q.push_back({SRC_A, a_q[i].d});
    fork
      run_a();
      run_b();
    join
    wait_drain("t5_drain");
    check("t5_n_out", out_cyc.size(), 8);
    if (out_cyc.size() == 8) begin
      check("t5_a_stream", out_cyc[3] - out_cyc[0], 3);
      check("t5_rotate_gap", out_cyc[4] - out_cyc[3], 2);
    end

    // m_ready low for 3 cycles inside an A burst
    for (int i = 0; i < 4; i++) begin
      r = 5'($urandom_range(0, 31));
      a_q.push_back('{d: r, last: (i == 3)});
      exp_q.push_back({SRC_A, r});
    end
    fork
      run_a();
      begin
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!m_valid && w0 < 50);
        check("t6_saw_valid", m_valid, 1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        held = {m_src, m_data};
        check("t6_stall_ready0", a_ready, 0);
        check("t6_stall_valid0", m_valid, 1);
        for (int i = 1; i < 3; i++) begin
          @(negedge clk);
          check("t6_stall_hold", {m_src, m_data}, held);
          check("t6_stall_ready", a_ready, 0);
          check("t6_stall_valid", m_valid, 1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_drain("t6_drain");

    // random back-pressure with random packet boundaries
    for (int i = 0; i < 12; i++) begin
      r = 5'($urandom_range(0, 31));
      a_q.push_back('{d: r, last: ($urandom_range(0, 3) == 0)});
      exp_q.push_back({SRC_A, r});
    end
    bp_on = 1'b1;
    fork
      begin
        run_a();
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("t7_drain");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
